instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning instruction width.
REQ-003 SHALL have parameter DEPTH, default 4 (power of 2, >=2), meaning prefetch buffer entries.
REQ-004 SHALL have port clk, input, 1, meaning single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 SHALL have port imem_en, output, 1, meaning instruction memory read request this cycle.
REQ-007 SHALL have port imem_addr, output, ADDR_W, meaning word address of the request.
REQ-008 SHALL have port imem_data, input, DATA_W, meaning read data, valid exactly 1 cycle after an imem_en cycle.
REQ-009 SHALL have port out_valid, output, 1, meaning out_instr/out_pc hold a fetched instruction.
REQ-010 SHALL have port out_ready, input, 1, meaning the cpu accepts the instruction this cycle.
REQ-011 SHALL have port out_instr, output, DATA_W, meaning the instruction at the buffer head.
REQ-012 SHALL have port out_pc, output, ADDR_W, meaning the address of out_instr.
REQ-013 SHALL have port redirect_valid, input, 1, meaning the cpu takes a branch/jump.
REQ-014 SHALL have port redirect_pc, input, ADDR_W, meaning the target address.
REQ-015 SHALL have port halt, input, 1, meaning stop issuing new fetches (level).

Function
REQ-016 SHALL keep fetch PC register; each issued request SHALL use imem_addr = PC, then PC <= PC+1 modulo 2^ADDR_W (2^ADDR_W-1 wraps to 0).
REQ-017 SHALL implement FSM states RUN, HALT, REDIR; imem_en SHALL be asserted only in RUN.
REQ-018 SHALL transition RUN->HALT when halt=1 and redirect_valid=0; HALT->RUN when halt=0; HALT SHALL preserve PC.
REQ-019 SHALL, when redirect_valid=1 in any state, load PC <= redirect_pc, flush the buffer, discard any in-flight response, issue no request that cycle, and enter REDIR.
REQ-020 SHALL leave REDIR after exactly 1 cycle, to HALT if halt=1, else RUN; redirect_valid in REDIR SHALL be honoured again per REQ-019.
REQ-021 SHALL, in RUN, assert imem_en iff count + inflight < DEPTH, where count = buffered entries and inflight = 1 if imem_en was asserted the previous cycle and not discarded (both registered values).
REQ-022 SHALL push {imem_data, request address} into the buffer on the cycle after a non-discarded request; the buffer SHALL never overflow.
REQ-023 SHALL drive out_valid = (count != 0), with out_instr/out_pc from the head entry; pop SHALL occur on out_valid & out_ready.
REQ-024 SHALL allow simultaneous push and pop on one cycle, count unchanged.
REQ-025 SHALL, if redirect_valid and out_valid & out_ready coincide, treat the head as consumed and flush all remaining entries; out_valid SHALL be 0 the next cycle.
REQ-026 SHALL sustain 1 instruction/cycle with out_ready held 1 and no halt/redirect, after a 2-cycle initial latency from first imem_en to out_valid (request, then push).
REQ-027 SHALL keep out_instr/out_pc stable while out_valid=1 and out_ready=0.
REQ-028 SHALL, in HALT, complete the in-flight response and keep presenting buffered entries until drained.

Reset
REQ-029 SHALL, on rst_n=0, asynchronously set PC=0, state=RUN, count=0, inflight=0, imem_en=0, out_valid=0; out_instr/out_pc SHALL be 0.
REQ-030 SHALL, on reset asserted mid-operation, discard buffered and in-flight data; first request after release SHALL be to address 0 on the first rising edge with rst_n=1.

Verification
REQ-031 SHALL verify streaming: ROM word[i]=i+0x100, out_ready=1 -> out_pc 0,1,2,... consecutive cycles, out_instr=0x100,0x101,..., first out_valid 2 cycles after first imem_en.
REQ-032 SHALL verify backpressure: out_ready=0 for 10 cycles -> exactly 4 entries buffered, imem_en=0 while full, head pc=0 stable; release -> pcs 0..n continuous, no loss/duplicate.
REQ-033 SHALL verify redirect: redirect_valid=1, redirect_pc=0x40 while entries buffered and one in flight -> next cycle out_valid=0, no imem_en; following cycle imem_en with addr 0x40; first delivered out_pc=0x40.
REQ-034 SHALL verify halt: halt=1 for 8 cycles -> imem_en=0, buffer drains, PC preserved; halt=0 -> fetch resumes at next sequential address.
REQ-035 SHALL verify wrap: redirect_pc=0xFE, ADDR_W=8 -> delivered pcs 0xFE,0xFF,0x00,0x01.
REQ-036 SHALL verify reset mid-stream: rst_n=0 for 3 cycles with full buffer -> out_valid=0, imem_en=0 immediately; after release first imem_addr=0.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit with a small prefetch buffer.
//
// Issues sequential word-address reads to a 1-cycle-latency instruction
// memory. Each response is queued together with its address and presented
// to the CPU through a valid/ready handshake. The CPU can redirect the fetch
// stream (branch/jump) or stall new fetches with a level-sensitive halt.
//
// Ports:
//   clk            - clock, rising edge
//   rst_n          - asynchronous active-low reset
//   imem_en        - memory read request this cycle
//   imem_addr      - word address of the request
//   imem_data      - read data, valid the cycle after imem_en
//   out_valid      - out_instr/out_pc hold a fetched instruction
//   out_ready      - CPU accepts the head instruction this cycle
//   out_instr      - instruction at the buffer head
//   out_pc         - address of out_instr
//   redirect_valid - CPU takes a branch/jump
//   redirect_pc    - branch/jump target
//   halt           - stop issuing new fetches (level)
module instr_fetch #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;

    typedef enum logic [1:0] {
        RUN,
        HALT,
        REDIR
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] req_addr;
    logic              inflight;
    logic [CW-1:0]     count;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [DATA_W-1:0] buf_instr [DEPTH];
    logic [ADDR_W-1:0] buf_pc    [DEPTH];
    logic [OW-1:0]     occupancy;
    logic              fetch;
    logic              push, pop;

    // Buffered entries plus the outstanding response; a request is only
    // issued when a slot is guaranteed for its data, so no overflow.
    assign occupancy = OW'(count) + OW'(inflight);

    always_comb begin
        state_n = state;
        pc_n    = pc;
        fetch   = 1'b0;
        if (redirect_valid) begin
            state_n = REDIR;
            pc_n    = redirect_pc;
        end else begin
            case (state)
                RUN: begin
                    fetch = (occupancy < OW'(DEPTH));
                    if (halt) state_n = HALT;
                end
                HALT: begin
                    if (!halt) state_n = RUN;
                end
                REDIR: begin
                    state_n = halt ? HALT : RUN;
                end
                default: state_n = RUN;
            endcase
            if (fetch) pc_n = pc + ADDR_W'(1);
        end
    end

    // The register state already sits at its reset values while rst_n is
    // low, but the request strobe is combinational, so gate it explicitly.
    assign imem_en   = fetch & rst_n;
    assign imem_addr = pc;

    // A response arriving alongside a redirect belongs to the old stream.
    assign push = inflight & ~redirect_valid;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pc       <= '0;
            req_addr <= '0;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            inflight <= imem_en;
            if (imem_en) req_addr <= pc;
            if (redirect_valid) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= imem_data;
            buf_pc[wr_ptr]    <= req_addr;
        end
    end

    assign out_valid = (count != '0);
    assign out_instr = out_valid ? buf_instr[rd_ptr] : '0;
    assign out_pc    = out_valid ? buf_pc[rd_ptr]    : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized and directed stimulus for instr_fetch, checked
// every cycle against a queue-based reference model of the fetch unit.
module tb_instr_fetch;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              halt = 1'b0;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt          (halt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] rom(input int a);
        return DATA_W'(32'h100 + a);
    endfunction

    // Reference model: fetched-but-undelivered addresses in a queue, one
    // outstanding memory response, and two flags saying whether fetching is
    // blocked this cycle (last cycle was a redirect, or halt was seen).
    int q[$];
    bit m_infl;
    int m_infl_addr;
    int m_pc;
    bit m_redir;
    bit m_halt;

    int cyc = 0;
    int first_en_cyc = -1;
    int first_valid_cyc = -1;

    task automatic model_reset();
        q.delete();
        m_infl  = 1'b0;
        m_pc    = 0;
        m_redir = 1'b0;
        m_halt  = 1'b0;
        first_en_cyc    = -1;
        first_valid_cyc = -1;
    endtask

    task automatic step(input bit rdy, input bit hlt, input bit rdr, input int rpc);
        bit exp_en;
        bit exp_valid;
        bit pop;
        @(negedge clk);
        rst_n          = 1'b1;
        out_ready      = rdy;
        halt           = hlt;
        redirect_valid = rdr;
        redirect_pc    = ADDR_W'(rpc);
        imem_data      = m_infl ? rom(m_infl_addr) : DATA_W'($urandom);
        #1;
        exp_en    = !rdr && !m_redir && !m_halt && ((q.size() + int'(m_infl)) < DEPTH);
        exp_valid = (q.size() != 0);
        check("imem_en", imem_en, exp_en);
        if (exp_en) check("imem_addr", imem_addr, m_pc);
        check("out_valid", out_valid, exp_valid);
        if (exp_valid) begin
            check("out_pc", out_pc, q[0]);
            check("out_instr", out_instr, rom(q[0]));
        end
        if (imem_en && first_en_cyc < 0) first_en_cyc = cyc;
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        @(posedge clk);
        cyc++;
        pop = exp_valid && rdy;
        if (rdr) begin
            q.delete();
            m_infl  = 1'b0;
            m_pc    = rpc % (1 << ADDR_W);
            m_redir = 1'b1;
            m_halt  = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (m_infl) q.push_back(m_infl_addr);
            m_infl      = exp_en;
            m_infl_addr = m_pc;
            if (exp_en) m_pc = (m_pc + 1) % (1 << ADDR_W);
            m_redir = 1'b0;
            m_halt  = hlt;
        end
    endtask

    // Holds reset low for n cycles; the next step() releases it.
    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            check("rst_imem_en", imem_en, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_instr", out_instr, 0);
            check("rst_out_pc", out_pc, 0);
        end
    endtask

    initial begin
        bit h;

        // Streaming with the CPU always ready.
        do_reset(2);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 0);
        check("stream_latency", first_valid_cyc - first_en_cyc, 2);

        // Backpressure from reset: buffer fills, head stays at pc 0.
        do_reset(2);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 0);
        #1;
        check("bp_head_pc", out_pc, 0);
        check("bp_full_no_fetch", imem_en, 0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 0);

        // Redirect with entries buffered and one response in flight.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b1, 'h40);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 0);

        // Halt: no fetches, buffer drains, then resume sequentially.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 0);

        // Address wrap through a redirect near the top of the space.
        step(1'b1, 1'b0, 1'b1, 'hFE);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 0);

        // Reset mid-stream with a full buffer.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 0);
        do_reset(3);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 0);

        // Randomized mix of backpressure, halt, redirect and reset.
        h = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(11, 0) == 0) h = ~h;
            if ($urandom_range(599, 0) == 0) begin
                do_reset(int'($urandom_range(3, 1)));
            end else begin
                step($urandom_range(3, 0) != 0, h,
                     $urandom_range(19, 0) == 0,
                     int'($urandom_range(255, 0)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
